wb_trace_sink: RTL and testbench



---
 rtl/wb_trace_pkg.sv | 16 +
 rtl/wb_shadow_regs.sv | 53 +++++
 rtl/wb_trace_sink.sv | 136 +++++++++++++
 tb/tb_wb_trace_sink.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared constants and types for the writeback trace sink.
package wb_trace_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int NREGS    = 32;

  localparam logic [REG_AW-1:0] LAST_IDX = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/wb_shadow_regs.sv
// Shadow architectural register file: one write port (x0 suppressed),
// one combinational read port that forwards a same-cycle write.
module wb_shadow_regs
  import wb_trace_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra,
  output logic [XLEN-1:0]   rd
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // next-state of the register array
  always_comb begin
    mem_d = mem_q;
    if (we && (wa != 5'd0)) begin
      mem_d[wa] = wd;
    end else begin
      mem_d = mem_q;
    end
  end

  // array storage with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // read port; a write to the addressed entry this cycle wins over storage
  always_comb begin
    rd = '0;
    if (ra == 5'd0) begin
      rd = '0;
    end else if (we && (wa == ra)) begin
      rd = wd;
    end else begin
      rd = mem_q[ra];
    end
  end

endmodule

// File: rtl/wb_trace_sink.sv
// Writeback trace sink: shadows the core register file, counts commits and
// streams all 32 registers over valid/ready on each rising edge of dump.
module wb_trace_sink
  import wb_trace_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_e,
  input  logic [4:0]        wb_a,
  input  logic [XLEN-1:0]   wb_d,
  input  logic              dump,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_idx,
  output logic [XLEN-1:0]   out_data,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [CNT_W-1:0]  commit_cnt
);

  dump_state_t       state_q, state_d;
  logic              dump_q, dump_d;
  logic [4:0]        idx_q, idx_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              start_s;
  logic              hs_s;
  logic              commit_s;
  logic [4:0]        rd_addr_s;
  logic [XLEN-1:0]   rd_data_s;

  assign start_s   = dump && !dump_q;
  assign hs_s      = valid_q && out_ready;
  assign commit_s  = wb_e && (wb_a != 5'd0);
  // in IDLE the next beat to load is x0, in SEND it is the one after the current
  assign rd_addr_s = (state_q == SEND) ? (idx_q + 5'd1) : 5'd0;

  wb_shadow_regs #(
    .XLEN (XLEN)
  ) u_regs (
    .clk   (clk),
    .reset (reset),
    .we    (wb_e),
    .wa    (wb_a),
    .wd    (wb_d),
    .ra    (rd_addr_s),
    .rd    (rd_data_s)
  );

  // dump sequencer and beat loading
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = SEND;
          idx_d   = rd_addr_s;
          data_d  = rd_data_s;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (hs_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d  = rd_addr_s;
            data_d = rd_data_s;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // registered status flags, edge detect and commit counter
  always_comb begin
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    dump_d  = dump;
    if (commit_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dump_q  <= 1'b0;
      idx_q   <= 5'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dump_q  <= dump_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_data   = data_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_trace_sink.sv
// Directed bench for wb_trace_sink; a second instance with a 4-bit counter
// shares the inputs to exercise counter wrap.
module tb_wb_trace_sink;

  logic        clk = 1'b0;
  logic        reset, wb_e, dump, out_ready;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;

  logic        out_valid, dump_busy, dump_done;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic [31:0] commit_cnt;

  logic        v4, busy4, done4;
  logic [4:0]  idx4;
  logic [31:0] data4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_mem [32];
  int hs_cnt, done_cnt, last_hs, done_c;

  wb_trace_sink #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .dump(dump), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .dump_busy(dump_busy),
    .dump_done(dump_done), .commit_cnt(commit_cnt)
  );

  wb_trace_sink #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .dump(dump), .out_valid(v4), .out_ready(out_ready),
    .out_idx(idx4), .out_data(data4), .dump_busy(busy4),
    .dump_done(done4), .commit_cnt(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_e = 1'b1; wb_a = a; wb_d = d;
    tick();
    wb_e = 1'b0;
    if (a != 5'd0) exp_mem[a] = d;
  endtask

  // mode 0: ready high; 1: ready toggles; 2: stall + forwarding + spurious dump edge
  task automatic run_dump(input int ncyc, input int mode);
    logic        pstall;
    logic [4:0]  pidx;
    logic [31:0] pdata;
    hs_cnt = 0; done_cnt = 0; last_hs = -1; done_c = -1; pstall = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      out_ready = 1'b1;
      wb_e = 1'b0;
      if (mode == 1) out_ready = ((c % 2) == 0);
      if (mode == 2) begin
        case (c)
          2: begin out_ready = 1'b0; wb_e = 1'b1; wb_a = 5'd2; wb_d = 32'h0000_0055; end
          3: begin wb_e = 1'b1; wb_a = 5'd3; wb_d = 32'hFEDC_BA98; exp_mem[3] = 32'hFEDC_BA98; end
          5: dump = 1'b0;
          6: dump = 1'b1;
          default: ;
        endcase
      end
      if (c == 0) begin
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_busy", 64'(dump_busy), 64'd1);
      end
      if (pstall) begin
        chk("stall_idx", 64'(out_idx), 64'(pidx));
        chk("stall_data", 64'(out_data), 64'(pdata));
      end
      if (out_valid && out_ready) begin
        chk("beat_idx", 64'(out_idx), 64'(hs_cnt));
        chk("beat_data", 64'(out_data), 64'(exp_mem[out_idx]));
        hs_cnt++;
        last_hs = c;
      end
      if (dump_done) begin
        done_cnt++;
        done_c = c;
        chk("done_valid_low", 64'(out_valid), 64'd0);
      end
      pstall = out_valid && !out_ready;
      pidx = out_idx;
      pdata = out_data;
      tick();
    end
    wb_e = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
    reset = 1'b1; wb_e = 1'b0; wb_a = 5'd0; wb_d = 32'd0; dump = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(dump_busy), 64'd0);
    chk("rst_done", 64'(dump_done), 64'd0);
    chk("rst_cnt", 64'(commit_cnt), 64'd0);

    wr(5'd1, 32'hDEAD_BEEF);
    wr(5'd2, 32'h1234_5678);
    wr(5'd7, 32'h0000_0004);
    wr(5'd0, 32'hFFFF_FFFF);
    chk("cnt_after_writes", 64'(commit_cnt), 64'd3);
    chk("cnt4_after_writes", 64'(cnt4), 64'd3);

    // plain dump, ready held high
    dump = 1'b1; tick();
    run_dump(36, 0);
    chk("d1_beats", 64'(hs_cnt), 64'd32);
    chk("d1_last_hs", 64'(last_hs), 64'd31);
    chk("d1_done_cnt", 64'(done_cnt), 64'd1);
    chk("d1_done_cycle", 64'(done_c), 64'd32);
    chk("d1_idle_busy", 64'(dump_busy), 64'd0);

    // backpressure
    dump = 1'b0; tick();
    dump = 1'b1; tick();
    run_dump(68, 1);
    chk("bp_beats", 64'(hs_cnt), 64'd32);
    chk("bp_last_hs", 64'(last_hs), 64'd62);
    chk("bp_done_cnt", 64'(done_cnt), 64'd1);
    chk("bp_done_cycle", 64'(done_c), 64'd63);

    // forwarding, late write to a loaded beat, ignored second edge
    dump = 1'b0; tick();
    dump = 1'b1; tick();
    run_dump(40, 2);
    exp_mem[2] = 32'h0000_0055;
    chk("fw_beats", 64'(hs_cnt), 64'd32);
    chk("fw_last_hs", 64'(last_hs), 64'd32);
    chk("fw_done_cnt", 64'(done_cnt), 64'd1);
    chk("fw_cnt", 64'(commit_cnt), 64'd5);

    // dump held high for 100 cycles
    dump = 1'b0; tick();
    dump = 1'b1; tick();
    run_dump(100, 0);
    chk("hold_beats", 64'(hs_cnt), 64'd32);
    chk("hold_done_cnt", 64'(done_cnt), 64'd1);

    // reset in the middle of a dump
    dump = 1'b0; tick();
    dump = 1'b1; out_ready = 1'b1; tick();
    for (int i = 0; i < 10; i++) tick();
    chk("mid_idx", 64'(out_idx), 64'd10);
    reset = 1'b1; tick();
    reset = 1'b0; dump = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(dump_busy), 64'd0);
    chk("mid_rst_cnt", 64'(commit_cnt), 64'd0);
    chk("mid_rst_idx", 64'(out_idx), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    tick();
    chk("mid_rst_no_done", 64'(dump_done), 64'd0);
    dump = 1'b1; tick();
    run_dump(36, 0);
    chk("zero_beats", 64'(hs_cnt), 64'd32);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);
    dump = 1'b0;

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) wr(5'd5, 32'(i + 1));
    chk("cnt32_17", 64'(commit_cnt), 64'd17);
    chk("cnt4_wrap", 64'(cnt4), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
